// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI arbiter.
// Holds the FSM state encoding and counter sizing.
package sd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        HOLD
    } state_t;

    localparam logic IDLE_MOSI    = 1'b1;
    localparam int   BIT_CNT      = 8;
    localparam int   FAST_DIV_DEF = 2;
    localparam int   SLOW_DIV_DEF = 32;
    localparam int   DIV_MAX      = (FAST_DIV_DEF > SLOW_DIV_DEF) ?
                                    FAST_DIV_DEF : SLOW_DIV_DEF;
    localparam int   CNT_W        = $clog2(DIV_MAX) + 1;

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter: divider, edge counter, shift registers.
// o_fin is combinational so the caller can leave SHIFT on the last edge.
module spi_byte_engine
    import sd_spi_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_div,
    input  logic [7:0]       i_wdata,
    input  logic             i_miso,
    output logic             o_sck,
    output logic             o_mosi,
    output logic [7:0]       o_rdata,
    output logic             o_fin
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [3:0]       LAST_EDGE = 4'(2 * BIT_CNT - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [3:0]       r_edge;
    logic [6:0]       r_tx;
    logic [7:0]       r_rx;
    logic             r_sck;
    logic             r_mosi;
    logic             w_tick;

    assign w_tick  = r_active && (r_cnt == '0);
    assign o_fin   = w_tick && (r_edge == LAST_EDGE);
    assign o_sck   = r_sck;
    assign o_mosi  = r_mosi;
    assign o_rdata = r_rx;

    // Half-period timing; even edges rise and sample, odd edges fall and shift
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_div    <= '0;
            r_edge   <= '0;
            r_tx     <= '1;
            r_rx     <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= IDLE_MOSI;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= i_div - ONE;
            r_div    <= i_div;
            r_edge   <= '0;
            r_tx     <= i_wdata[6:0];
            r_sck    <= 1'b0;
            r_mosi   <= i_wdata[7];
        end else if (w_tick) begin
            r_cnt  <= r_div - ONE;
            r_edge <= r_edge + 4'd1;
            r_sck  <= ~r_sck;
            if (!r_edge[0]) begin
                r_rx <= {r_rx[6:0], i_miso};
            end else begin
                r_tx   <= {r_tx[5:0], 1'b1};
                r_mosi <= (r_edge == LAST_EDGE) ? IDLE_MOSI : r_tx[6];
            end
            if (r_edge == LAST_EDGE) begin
                r_active <= 1'b0;
            end
        end else if (r_active) begin
            r_cnt <= r_cnt - ONE;
        end
    end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Two-requester arbiter for the SD-card SPI link.
// Round-robin grant, chip-select lock across bytes, fast/slow clocking.
module sd_spi_arbiter
    import sd_spi_pkg::*;
#(
    parameter int FAST_DIV = FAST_DIV_DEF,
    parameter int SLOW_DIV = SLOW_DIV_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       req0_req,
    input  logic       req0_cs,
    input  logic       req0_slow,
    input  logic [7:0] req0_wdata,
    output logic       req0_gnt,
    output logic       req0_done,
    output logic [7:0] req0_rdata,
    input  logic       req1_req,
    input  logic       req1_cs,
    input  logic       req1_slow,
    input  logic [7:0] req1_wdata,
    output logic       req1_gnt,
    output logic       req1_done,
    output logic [7:0] req1_rdata,
    output logic       busy,
    output logic       sd_cs,
    output logic       sd_sck,
    output logic       sd_sdi,
    input  logic       sd_sdo
);

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic       r_cs_l;
    logic       r_sd_cs;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_done0;
    logic       r_done1;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;

    logic             w_start;
    logic             w_sel;
    logic             w_cs;
    logic             w_slow;
    logic             w_owner_cs;
    logic             w_fin;
    logic [7:0]       w_wdata;
    logic [7:0]       w_rdata;
    logic [CNT_W-1:0] w_div;

    // Decide whether a byte starts this cycle and for whom
    always_comb begin
        w_start = 1'b0;
        w_sel   = r_owner;
        case (r_state)
            IDLE: begin
                if (req0_req || req1_req) begin
                    w_start = 1'b1;
                    w_sel   = (req0_req && req1_req) ? ~r_last : req1_req;
                end
            end
            HOLD: begin
                w_start = r_owner ? req1_req : req0_req;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    assign w_cs       = w_sel ? req1_cs : req0_cs;
    assign w_slow     = w_sel ? req1_slow : req0_slow;
    assign w_wdata    = w_sel ? req1_wdata : req0_wdata;
    assign w_owner_cs = r_owner ? req1_cs : req0_cs;
    assign w_div      = w_slow ? CNT_W'(SLOW_DIV) : CNT_W'(FAST_DIV);

    spi_byte_engine u_engine (
        .i_clk   (clk_sys),
        .i_rst   (reset),
        .i_start (w_start),
        .i_div   (w_div),
        .i_wdata (w_wdata),
        .i_miso  (sd_sdo),
        .o_sck   (sd_sck),
        .o_mosi  (sd_sdi),
        .o_rdata (w_rdata),
        .o_fin   (w_fin)
    );

    // Arbitration FSM with registered grant/done pulses and card select
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_cs_l   <= 1'b0;
            r_sd_cs  <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= 8'h00;
            r_rdata1 <= 8'h00;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE, HOLD: begin
                    if (w_start) begin
                        r_state <= SHIFT;
                        r_owner <= w_sel;
                        r_cs_l  <= w_cs;
                        r_sd_cs <= ~w_cs;
                        r_gnt0  <= ~w_sel;
                        r_gnt1  <= w_sel;
                    end else if (r_state == HOLD && !w_owner_cs) begin
                        r_state <= IDLE;
                        r_sd_cs <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_fin) begin
                        r_state <= DONE;
                        r_last  <= r_owner;
                        if (r_owner) begin
                            r_done1  <= 1'b1;
                            r_rdata1 <= w_rdata;
                        end else begin
                            r_done0  <= 1'b1;
                            r_rdata0 <= w_rdata;
                        end
                    end
                end
                DONE: begin
                    if (r_cs_l) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= IDLE;
                        r_sd_cs <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_gnt   = r_gnt0;
    assign req1_gnt   = r_gnt1;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;
    assign sd_cs      = r_sd_cs;
    assign busy       = (r_state != IDLE);

endmodule
